// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_if
// Purpose  : Bundle of the two requester command ports, the read-result ports
//            and the shared single-port RAM signals seen by ram_arbiter.
// Signals  : req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 - requester cmds
//            gnt0/gnt1, rvalid0/rvalid1, rdata0/rdata1        - responses
//            busy                                              - arbiter busy
//            wrEn, wrAddr, wrData, rdAddr                      - RAM controls
//            rdData                                            - RAM read data
// Modports : slave  - the arbiter
//            master - requesters plus RAM model (environment side)
// Revision : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic [ADDR_W-1:0] rdAddr;
  logic [DATA_W-1:0] rdData;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, rdData,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy,
           wrEn, wrAddr, wrData, rdAddr
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, rdData,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, busy,
           wrEn, wrAddr, wrData, rdAddr
  );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Two-requester arbiter in front of a single-port RAM. Accepts at
//            most one command every two cycles (IDLE -> WRITE/READ -> IDLE),
//            round-robin between simultaneous requesters.
// Ports    : clk  - clock, all state updates on the rising edge
//            rstN - synchronous active-low reset
//            bus  - ram_arbiter_if.slave (requesters, responses, RAM port)
// Config   : RAM_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins
//            simultaneous requests and no round-robin pointer exists.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rstN,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic              sel_q;      // requester owning the command in flight
  logic [ADDR_W-1:0] wrAddr_q;
  logic [DATA_W-1:0] wrData_q;
  logic [ADDR_W-1:0] rdAddr_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              rvalid0_q;
  logic              rvalid1_q;
  logic              grant0;
  logic              grant1;
  logic              prefer1;    // 1: requester 1 wins a tie

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign prefer1 = 1'b0;
`else
  logic              pref_q;
  assign prefer1 = pref_q;
`endif

  // Grants are only possible in IDLE and outside reset; a sole requester
  // always wins, ties go to the preferred requester.
  always_comb begin
    state_d = state_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rstN) begin
          if (bus.req0 && (!bus.req1 || !prefer1)) begin
            grant0 = 1'b1;
          end else if (bus.req1) begin
            grant1 = 1'b1;
          end
        end
        if (grant0) begin
          state_d = bus.we0 ? S_WRITE : S_READ;
        end else if (grant1) begin
          state_d = bus.we1 ? S_WRITE : S_READ;
        end
      end
      S_WRITE, S_READ: state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q   <= S_IDLE;
      sel_q     <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
      rdAddr_q  <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      pref_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;

      // Command fields are captured at the grant edge so the RAM sees them
      // during the following WRITE/READ cycle and they hold afterwards.
      if (grant0) begin
        sel_q <= 1'b0;
        if (bus.we0) begin
          wrAddr_q <= bus.addr0;
          wrData_q <= bus.wdata0;
        end else begin
          rdAddr_q <= bus.addr0;
        end
      end else if (grant1) begin
        sel_q <= 1'b1;
        if (bus.we1) begin
          wrAddr_q <= bus.addr1;
          wrData_q <= bus.wdata1;
        end else begin
          rdAddr_q <= bus.addr1;
        end
      end

`ifndef RAM_ARB_FIXED_PRIO_EN
      // Next tie goes to whoever was not just served.
      if (grant0) begin
        pref_q <= 1'b1;
      end else if (grant1) begin
        pref_q <= 1'b0;
      end
`endif

      // End of READ: capture the combinational RAM data for the owner only.
      if (state_q == S_READ) begin
        if (sel_q) begin
          rdata1_q  <= bus.rdData;
          rvalid1_q <= 1'b1;
        end else begin
          rdata0_q  <= bus.rdData;
          rvalid0_q <= 1'b1;
        end
      end
    end
  end

  assign bus.gnt0    = grant0;
  assign bus.gnt1    = grant1;
  assign bus.busy    = (state_q != S_IDLE);
  // Gated by rstN so a reset during WRITE never commits to the RAM.
  assign bus.wrEn    = rstN && (state_q == S_WRITE);
  assign bus.wrAddr  = wrAddr_q;
  assign bus.wrData  = wrData_q;
  assign bus.rdAddr  = rdAddr_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter: directed vector table,
//            directed multi-cycle sequences (fill/readback, aborted commands)
//            and a randomized phase scored against a transaction-level model.
// Config   : honours RAM_ARB_FIXED_PRIO_EN in its expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

  logic clk;
  logic rstN;
  logic ram_init;
  logic [7:0] ram [16];

  int n_checks = 0;
  int n_fail   = 0;

  ram_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  ram_arbiter #(.ADDR_W(4), .DATA_W(8)) u_dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port RAM: synchronous write, combinational read.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 16; i++) begin
        ram[i] <= (i == 1) ? 8'h1A : ((i == 2) ? 8'h1B : 8'h00);
      end
    end else if (bus.wrEn) begin
      ram[bus.wrAddr] <= bus.wrData;
    end
  end
  assign bus.rdData = ram[bus.rdAddr];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic r, input logic w,
                         input logic [3:0] a, input logic [7:0] d);
    if (id == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // Waits (bounded) for the grant of a held request; returns at grant edge + #1.
  task automatic wait_gnt(input int id, input string tag, output logic got);
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      got = (id == 0) ? bus.gnt0 : bus.gnt1;
      @(posedge clk); #1;
    end
    if (!got) check({tag, "_gnt_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic do_cmd(input int id, input logic w, input logic [3:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd, input string tag);
    logic got;
    set_req(id, 1'b1, w, a, d);
    wait_gnt(id, tag, got);
    set_req(id, 1'b0, 1'b0, 4'd0, 8'd0);
    if (got) begin
      if (w) begin
        @(negedge clk);
        check({tag, "_wr"}, {bus.wrEn, bus.wrAddr, bus.wrData}, {1'b1, a, d});
        @(posedge clk); #1;
      end else begin
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        if (id == 0) check({tag, "_rd"}, {bus.rvalid0, bus.rvalid1, bus.rdata0}, {2'b10, exp_rd});
        else         check({tag, "_rd"}, {bus.rvalid0, bus.rvalid1, bus.rdata1}, {2'b01, exp_rd});
        @(posedge clk); #1;
      end
    end
  endtask

  typedef struct {
    logic       rst_n;
    logic       r0; logic w0; logic [3:0] a0; logic [7:0] d0;
    logic       r1; logic w1; logic [3:0] a1; logic [7:0] d1;
    logic [5:0] eflag;  // {gnt0, gnt1, wrEn, busy, rvalid0, rvalid1}
    logic [3:0] ewa;
    logic [7:0] ewd;
    logic [7:0] erd0;
    logic [7:0] erd1;
  } vec_t;

  function automatic vec_t mk(logic rst_n, logic r0, logic w0, logic [3:0] a0, logic [7:0] d0,
                              logic r1, logic w1, logic [3:0] a1, logic [7:0] d1,
                              logic [5:0] ef, logic [3:0] ewa, logic [7:0] ewd,
                              logic [7:0] erd0, logic [7:0] erd1);
    vec_t v;
    v.rst_n = rst_n; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.eflag = ef; v.ewa = ewa; v.ewd = ewd; v.erd0 = erd0; v.erd1 = erd1;
    return v;
  endfunction

`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam logic P = 1'b0;  // no tie in rows 3-5 when ties always go to 0
`else
  localparam logic P = 1'b1;
`endif

  // Transaction-level model state for the random phase.
  logic       pend [2];
  logic       pwe  [2];
  logic [3:0] pa   [2];
  logic [7:0] pd   [2];
  logic [7:0] mmem [16];
  logic [7:0] mrd  [2];
  logic [7:0] rvd  [2];
  int         rv_at [2];

  initial begin
    vec_t vecs [12];
    logic got;
    int   free_at, last, we_at, win;
    logic [3:0] ewa;
    logic [7:0] ewd;
    logic busy_e, we_e, rv0_e, rv1_e;

    rstN = 1'b0;
    ram_init = 1'b1;
    set_req(0, 1'b0, 1'b0, 4'd0, 8'd0);
    set_req(1, 1'b0, 1'b0, 4'd0, 8'd0);
    @(posedge clk); #1;
    ram_init = 1'b0;

    // ---- vector table: reset, contention with round robin, write/read ----
    vecs[0]  = mk(1'b0, 1'b1,1'b1,4'd3,8'h19, 1'b1,1'b0,4'd2,8'h00, 6'b000000,4'd0,8'h00,8'h00,8'h00);
    vecs[1]  = mk(1'b0, 1'b1,1'b1,4'd3,8'h19, 1'b1,1'b0,4'd2,8'h00, 6'b000000,4'd0,8'h00,8'h00,8'h00);
    vecs[2]  = mk(1'b1, 1'b1,1'b0,4'd1,8'h00, 1'b1,1'b0,4'd2,8'h00, 6'b100000,4'd0,8'h00,8'h00,8'h00);
    vecs[3]  = mk(1'b1, P,   1'b1,4'd3,8'h19, 1'b1,1'b0,4'd2,8'h00, 6'b000100,4'd0,8'h00,8'h00,8'h00);
    vecs[4]  = mk(1'b1, P,   1'b1,4'd3,8'h19, 1'b1,1'b0,4'd2,8'h00, 6'b010010,4'd0,8'h00,8'h1A,8'h00);
    vecs[5]  = mk(1'b1, P,   1'b1,4'd3,8'h19, 1'b0,1'b0,4'd0,8'h00, 6'b000100,4'd0,8'h00,8'h1A,8'h00);
    vecs[6]  = mk(1'b1, 1'b1,1'b1,4'd3,8'h19, 1'b0,1'b0,4'd0,8'h00, 6'b100001,4'd0,8'h00,8'h1A,8'h1B);
    vecs[7]  = mk(1'b1, 1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,4'd0,8'h00, 6'b001100,4'd3,8'h19,8'h1A,8'h1B);
    vecs[8]  = mk(1'b1, 1'b1,1'b0,4'd3,8'h00, 1'b0,1'b0,4'd0,8'h00, 6'b100000,4'd3,8'h19,8'h1A,8'h1B);
    vecs[9]  = mk(1'b1, 1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,4'd0,8'h00, 6'b000100,4'd3,8'h19,8'h1A,8'h1B);
    vecs[10] = mk(1'b1, 1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,4'd0,8'h00, 6'b000010,4'd3,8'h19,8'h19,8'h1B);
    vecs[11] = mk(1'b1, 1'b0,1'b0,4'd0,8'h00, 1'b0,1'b0,4'd0,8'h00, 6'b000000,4'd3,8'h19,8'h19,8'h1B);

    for (int k = 0; k < 12; k++) begin
      rstN = vecs[k].rst_n;
      set_req(0, vecs[k].r0, vecs[k].w0, vecs[k].a0, vecs[k].d0);
      set_req(1, vecs[k].r1, vecs[k].w1, vecs[k].a1, vecs[k].d1);
      @(negedge clk);
      check($sformatf("vec[%0d]", k),
            {bus.gnt0, bus.gnt1, bus.wrEn, bus.busy, bus.rvalid0, bus.rvalid1,
             bus.wrAddr, bus.wrData, bus.rdata0, bus.rdata1},
            {vecs[k].eflag, vecs[k].ewa, vecs[k].ewd, vecs[k].erd0, vecs[k].erd1});
      @(posedge clk); #1;
    end

    // ---- fill / readback by requester 1 ----
    for (int a = 0; a < 16; a++) do_cmd(1, 1'b1, 4'(a), 8'(25 + a), 8'd0, $sformatf("fill%0d", a));
    for (int a = 0; a < 16; a++) do_cmd(1, 1'b0, 4'(a), 8'd0, 8'(25 + a), $sformatf("rdbk%0d", a));

    // ---- reset during WRITE: nothing commits ----
    set_req(0, 1'b1, 1'b1, 4'd5, 8'h55);
    wait_gnt(0, "abort_wr", got);
    set_req(0, 1'b0, 1'b0, 4'd0, 8'd0);
    rstN = 1'b0;
    @(negedge clk);
    check("abort_wr_wrEn", {63'd0, bus.wrEn}, 64'd0);
    @(posedge clk); #1;
    rstN = 1'b1;
    check("abort_wr_ram", {56'd0, ram[5]}, 64'd30);
    do_cmd(0, 1'b0, 4'd5, 8'd0, 8'd30, "abort_wr_rdbk");

    // ---- reset during READ: no rvalid, results cleared ----
    set_req(1, 1'b1, 1'b0, 4'd7, 8'd0);
    wait_gnt(1, "abort_rd", got);
    set_req(1, 1'b0, 1'b0, 4'd0, 8'd0);
    rstN = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check($sformatf("abort_rd_quiet%0d", n),
            {46'd0, bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1}, 64'd0);
      @(posedge clk); #1;
    end

    // ---- randomized traffic against the transaction-level model ----
    for (int i = 0; i < 16; i++) mmem[i] = 8'(25 + i);
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; pwe[k] = 1'b0; pa[k] = 4'd0; pd[k] = 8'd0;
      mrd[k] = 8'd0; rvd[k] = 8'd0; rv_at[k] = -1;
    end
    free_at = 0; last = 1; we_at = -1; ewa = 4'd0; ewd = 8'd0;

    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!pend[k] && $urandom_range(0, 2) != 0) begin
          pend[k] = 1'b1;
          pwe[k]  = 1'($urandom_range(0, 1));
          pa[k]   = 4'($urandom_range(0, 15));
          pd[k]   = 8'($urandom_range(0, 255));
        end
        set_req(k, pend[k], pwe[k], pa[k], pd[k]);
      end
      @(negedge clk);
      busy_e = (c < free_at);
      win = -1;
      if (!busy_e) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        if (pend[0])      win = 0;
        else if (pend[1]) win = 1;
`else
        if (pend[0] && pend[1]) win = (last == 0) ? 1 : 0;
        else if (pend[0])       win = 0;
        else if (pend[1])       win = 1;
`endif
      end
      we_e  = (we_at == c);
      rv0_e = (rv_at[0] == c);
      rv1_e = (rv_at[1] == c);
      if (rv0_e) mrd[0] = rvd[0];
      if (rv1_e) mrd[1] = rvd[1];
      check($sformatf("rand[%0d]", c),
            {bus.gnt0, bus.gnt1, bus.wrEn, bus.busy, bus.rvalid0, bus.rvalid1,
             (we_e ? bus.wrAddr : 4'd0), (we_e ? bus.wrData : 8'd0), bus.rdata0, bus.rdata1},
            {(win == 0), (win == 1), we_e, busy_e, rv0_e, rv1_e,
             (we_e ? ewa : 4'd0), (we_e ? ewd : 8'd0), mrd[0], mrd[1]});
      if (win >= 0) begin
        if (pwe[win]) begin
          mmem[pa[win]] = pd[win];
          we_at = c + 1; ewa = pa[win]; ewd = pd[win];
        end else begin
          rv_at[win] = c + 2;
          rvd[win]   = mmem[pa[win]];
        end
        free_at   = c + 2;
        last      = win;
        pend[win] = 1'b0;
      end
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, 1'b0, 4'd0, 8'd0);
    set_req(1, 1'b0, 1'b0, 4'd0, 8'd0);
    repeat (3) begin @(posedge clk); #1; end

`ifdef RAM_ARB_FIXED_PRIO_EN
    // ---- fixed priority: requester 1 starves under continuous contention ----
    set_req(0, 1'b1, 1'b0, 4'd0, 8'd0);
    set_req(1, 1'b1, 1'b0, 4'd1, 8'd0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      check($sformatf("fixed[%0d]", n), {62'd0, bus.gnt0, bus.gnt1}, {62'd0, ~bus.busy, 1'b0});
      @(posedge clk); #1;
    end
    set_req(0, 1'b0, 1'b0, 4'd0, 8'd0);
    set_req(1, 1'b0, 1'b0, 4'd0, 8'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
